// File: rtl/conv_pixel_scheduler_pkg.sv
// Shared types and sizing helpers for the convolution pixel scheduler.
// Derived constants are functions because they depend on module parameters.
package conv_pixel_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Never narrower than one bit, so single-entry counters stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int pix_cyc(input int n_mem, input int cyc_mem);
      return n_mem * cyc_mem;
   endfunction

   function automatic int num_pix(input int width, input int n_mult);
      return width * width * n_mult;
   endfunction

endpackage

// File: rtl/conv_pixel_scheduler_feature_word_mux.sv
// Registered N-to-1 word selector with hold and synchronous clear.
module feature_word_mux
   import conv_pixel_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_WORDS  = 20,
   parameter int SEL_W      = clog2(NUM_WORDS)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          hold,
   input  logic [SEL_W-1:0]              sel,
   input  logic [DATA_WIDTH*NUM_WORDS-1:0] words,
   output logic [DATA_WIDTH-1:0]         q
);

   logic [DATA_WIDTH-1:0] q_q;
   logic [DATA_WIDTH-1:0] q_d;
   logic [DATA_WIDTH-1:0] sel_word;

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (sel == SEL_W'(k)) sel_word = words[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      q_d = q_q;
      if (clear)      q_d = '0;
      else if (!hold) q_d = sel_word;
   end

   always_ff @(posedge clock) begin
      if (reset) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/conv_pixel_scheduler.sv
// Control sequencer for one convolution layer: prime, run, drain, done,
// with stall, abort and time-multiplexed feature-memory selection.
module conv_pixel_scheduler
   import conv_pixel_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH        = 16,
   parameter int INPUT_NUM_MEM     = 20,
   parameter int CYCLES_PER_MEM    = 25,
   parameter int OUT_FEATURE_WIDTH = 10,
   parameter int NUM_ONEMULT       = 2,
   parameter int PIPE_LAT          = 4
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                hold,
   input  logic                                abort,
   input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_a_all,
   input  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0] in_feature_q_b_all,
   output logic [DATA_WIDTH-1:0]               in_feature_q_a_mux,
   output logic [DATA_WIDTH-1:0]               in_feature_q_b_mux,
   output logic                                mem_rden,
   output logic                                addr_adv,
   output logic                                accum_sload,
   output logic [clog2(INPUT_NUM_MEM)-1:0]     mem_sel,
   output logic                                pix_valid,
   output logic                                busy,
   output logic                                done
);

   localparam int PIX_CYC = pix_cyc(INPUT_NUM_MEM, CYCLES_PER_MEM);
   localparam int NUM_PIX = num_pix(OUT_FEATURE_WIDTH, NUM_ONEMULT);
   localparam int SEL_W   = clog2(INPUT_NUM_MEM);
   localparam int TAP_W   = clog2(CYCLES_PER_MEM);
   localparam int PIX_W   = clog2(NUM_PIX);
   localparam int LAT_W   = clog2(PIPE_LAT);

   localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(CYCLES_PER_MEM - 1);
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(INPUT_NUM_MEM - 1);
   localparam logic [PIX_W-1:0] PIX_MAX = PIX_W'(NUM_PIX - 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(PIPE_LAT - 1);

   state_e              state_q, state_d;
   logic [TAP_W-1:0]    tap_q, tap_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [PIPE_LAT-1:0] pv_q, pv_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic run;
   logic adv;
   logic pix_end;

   assign run     = (state_q == ST_RUN);
   assign adv     = run && !hold;
   assign pix_end = adv && (tap_q == TAP_MAX) && (sel_q == SEL_MAX);

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      sel_d   = sel_q;
      pix_d   = pix_q;
      lat_d   = lat_q;
      pv_d[0] = pix_end;
      for (int i = 1; i < PIPE_LAT; i++) pv_d[i] = pv_q[i-1];

      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         tap_d   = '0;
         sel_d   = '0;
         pix_d   = '0;
         lat_d   = '0;
         pv_d    = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d = ST_PRIME;
                  lat_d   = '0;
               end
            end
            ST_PRIME: begin
               lat_d = lat_q + 1'b1;
               if (lat_q == LAT_MAX) begin
                  lat_d   = '0;
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               // Nested wrap: taps inside memories inside pixels.
               if (!hold) begin
                  tap_d = tap_q + 1'b1;
                  if (tap_q == TAP_MAX) begin
                     tap_d = '0;
                     sel_d = sel_q + 1'b1;
                     if (sel_q == SEL_MAX) begin
                        sel_d = '0;
                        pix_d = pix_q + 1'b1;
                        if (pix_q == PIX_MAX) begin
                           pix_d   = '0;
                           state_d = ST_DRAIN;
                        end
                     end
                  end
               end
            end
            ST_DRAIN: begin
               lat_d = lat_q + 1'b1;
               if (lat_q == LAT_MAX) begin
                  lat_d   = '0;
                  state_d = ST_DONE;
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         sel_q   <= '0;
         pix_q   <= '0;
         lat_q   <= '0;
         pv_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         sel_q   <= sel_d;
         pix_q   <= pix_d;
         lat_q   <= lat_d;
         pv_q    <= pv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Stall gating must act in the same cycle, so these stay combinational.
   assign mem_rden    = (state_q == ST_PRIME) || adv;
   assign addr_adv    = (state_q == ST_PRIME) || adv;
   assign accum_sload = adv && (tap_q == '0) && (sel_q == '0);
   assign mem_sel     = sel_q;
   assign pix_valid   = pv_q[PIPE_LAT-1];
   assign busy        = busy_q;
   assign done        = done_q;

   feature_word_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (INPUT_NUM_MEM)
   ) u_mux_a (
      .clock (clock),
      .reset (reset),
      .clear (state_q == ST_IDLE),
      .hold  (run && hold),
      .sel   (sel_q),
      .words (in_feature_q_a_all),
      .q     (in_feature_q_a_mux)
   );

   feature_word_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WORDS  (INPUT_NUM_MEM)
   ) u_mux_b (
      .clock (clock),
      .reset (reset),
      .clear (state_q == ST_IDLE),
      .hold  (run && hold),
      .sel   (sel_q),
      .words (in_feature_q_b_all),
      .q     (in_feature_q_b_mux)
   );

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
// Randomized and directed bench for conv_pixel_scheduler against a
// progress-count reference model.
module tb_conv_pixel_scheduler;

   localparam int DW   = 16;
   localparam int NMEM = 3;
   localparam int CPM  = 2;
   localparam int OFW  = 2;
   localparam int NOM  = 1;
   localparam int PL   = 2;
   localparam int PCYC = NMEM * CPM;
   localparam int TOT  = PCYC * OFW * OFW * NOM;

   localparam int S_IDLE  = 0;
   localparam int S_PRIME = 1;
   localparam int S_RUN   = 2;
   localparam int S_DRAIN = 3;
   localparam int S_DONE  = 4;

   logic                 clock;
   logic                 reset;
   logic                 start;
   logic                 hold;
   logic                 abort;
   logic [DW*NMEM-1:0]   qa_all;
   logic [DW*NMEM-1:0]   qb_all;
   logic [DW-1:0]        qa_mux;
   logic [DW-1:0]        qb_mux;
   logic                 mem_rden;
   logic                 addr_adv;
   logic                 accum_sload;
   logic [1:0]           mem_sel;
   logic                 pix_valid;
   logic                 busy;
   logic                 done;

   conv_pixel_scheduler #(
      .DATA_WIDTH        (DW),
      .INPUT_NUM_MEM     (NMEM),
      .CYCLES_PER_MEM    (CPM),
      .OUT_FEATURE_WIDTH (OFW),
      .NUM_ONEMULT       (NOM),
      .PIPE_LAT          (PL)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .start              (start),
      .hold               (hold),
      .abort              (abort),
      .in_feature_q_a_all (qa_all),
      .in_feature_q_b_all (qb_all),
      .in_feature_q_a_mux (qa_mux),
      .in_feature_q_b_mux (qb_mux),
      .mem_rden           (mem_rden),
      .addr_adv           (addr_adv),
      .accum_sload        (accum_sload),
      .mem_sel            (mem_sel),
      .pix_valid          (pix_valid),
      .busy               (busy),
      .done               (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk;
   int n_fail;
   int cyc;
   int t0;

   int m_st;
   int m_lat;
   int m_k;
   logic [DW-1:0] m_mux_a;
   logic [DW-1:0] m_mux_b;
   int pv_due[$];

   logic [DW-1:0] word_a[NMEM];
   logic [DW-1:0] word_b[NMEM];
   bit const_w;

   int done_at, busy_at, done_n, probe_rel, probe_busy;
   int pv_rel[$];
   int sl_rel[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   task automatic rec_clear();
      done_at    = -1;
      busy_at    = -1;
      done_n     = 0;
      probe_busy = -1;
      pv_rel.delete();
      sl_rel.delete();
   endtask

   // One clock cycle: drive, compare at negedge, advance model.
   task automatic tick(input logic st, input logic hd,
                       input logic ab, input logic rs);
      int e_sel;
      bit e_adv, e_rden, e_sl, e_pv;
      int rel;
      start = st;
      hold  = hd;
      abort = ab;
      reset = rs;
      for (int k = 0; k < NMEM; k++) begin
         word_a[k] = const_w ? DW'(256 + k) : DW'($urandom);
         word_b[k] = const_w ? DW'(256 + k) : DW'($urandom);
         qa_all[k*DW +: DW] = word_a[k];
         qb_all[k*DW +: DW] = word_b[k];
      end
      @(negedge clock);

      e_sel  = (m_st == S_RUN) ? (m_k / CPM) % NMEM : 0;
      e_adv  = (m_st == S_RUN) && !hd;
      e_rden = (m_st == S_PRIME) || e_adv;
      e_sl   = e_adv && (m_k % PCYC == 0);
      e_pv   = (pv_due.size() > 0) && (pv_due[0] == cyc);

      chk("busy",      32'(busy),        32'(m_st != S_IDLE));
      chk("done",      32'(done),        32'(m_st == S_DONE));
      chk("mem_rden",  32'(mem_rden),    32'(e_rden));
      chk("addr_adv",  32'(addr_adv),    32'(e_rden));
      chk("sload",     32'(accum_sload), 32'(e_sl));
      chk("mem_sel",   32'(mem_sel),     32'(e_sel));
      chk("pix_valid", 32'(pix_valid),   32'(e_pv));
      chk("mux_a",     32'(qa_mux),      32'(m_mux_a));
      chk("mux_b",     32'(qb_mux),      32'(m_mux_b));

      rel = cyc - t0;
      if (busy && busy_at < 0) busy_at = rel;
      if (done) begin
         done_n++;
         if (done_at < 0) done_at = rel;
      end
      if (pix_valid)   pv_rel.push_back(rel);
      if (accum_sload) sl_rel.push_back(rel);
      if (rel == probe_rel) probe_busy = int'(busy);

      if (rs || m_st == S_IDLE) begin
         m_mux_a = '0;
         m_mux_b = '0;
      end else if (!(m_st == S_RUN && hd)) begin
         m_mux_a = word_a[e_sel];
         m_mux_b = word_b[e_sel];
      end

      if (e_pv) void'(pv_due.pop_front());
      if (rs || (ab && m_st != S_IDLE)) begin
         m_st  = S_IDLE;
         m_lat = 0;
         m_k   = 0;
         pv_due.delete();
      end else begin
         case (m_st)
            S_IDLE: if (st && !ab) begin
               m_st  = S_PRIME;
               m_lat = 0;
            end
            S_PRIME: begin
               m_lat++;
               if (m_lat == PL) begin
                  m_st = S_RUN;
                  m_k  = 0;
               end
            end
            S_RUN: if (!hd) begin
               if (m_k % PCYC == PCYC - 1) pv_due.push_back(cyc + PL);
               m_k++;
               if (m_k == TOT) begin
                  m_st  = S_DRAIN;
                  m_lat = 0;
               end
            end
            S_DRAIN: begin
               m_lat++;
               if (m_lat == PL) m_st = S_DONE;
            end
            default: m_st = S_IDLE;
         endcase
      end

      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic check_basic_offsets(input string tag);
      chk({tag, "_pv_n"}, 32'(pv_rel.size()), 32'd4);
      chk({tag, "_sl_n"}, 32'(sl_rel.size()), 32'd4);
      for (int j = 0; j < 4; j++) begin
         if (j < pv_rel.size()) chk({tag, "_pv_at"}, 32'(pv_rel[j]), 32'(10 + 6*j));
         if (j < sl_rel.size()) chk({tag, "_sl_at"}, 32'(sl_rel[j]), 32'(3 + 6*j));
      end
      chk({tag, "_done_at"}, 32'(done_at), 32'(29));
      chk({tag, "_done_n"},  32'(done_n),  32'd1);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      cyc       = 0;
      t0        = 0;
      probe_rel = -1;
      const_w   = 1'b0;
      m_st      = S_IDLE;
      m_lat     = 0;
      m_k       = 0;
      m_mux_a   = '0;
      m_mux_b   = '0;
      reset     = 1'b1;
      start     = 1'b1;
      hold      = 1'b0;
      abort     = 1'b0;
      qa_all    = '0;
      qb_all    = '0;
      rec_clear();
      @(posedge clock);
      #1;

      tick(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mux",  32'(qa_mux), 32'd0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);

      const_w = 1'b1;
      rec_clear();
      t0 = cyc;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 35; i++) tick(i == 8, 1'b0, 1'b0, 1'b0);
      chk("basic_busy_at", 32'(busy_at), 32'd1);
      check_basic_offsets("basic");
      const_w = 1'b0;

      rec_clear();
      t0 = cyc;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 40; i++) tick(1'b0, i >= 5 && i <= 7, 1'b0, 1'b0);
      chk("hold_done_at", 32'(done_at), 32'd32);
      chk("hold_pv_n",    32'(pv_rel.size()), 32'd4);

      rec_clear();
      t0 = cyc;
      probe_rel = 13;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 22; i++) tick(1'b0, 1'b0, i == 12, 1'b0);
      chk("abort_busy13", 32'(probe_busy), 32'd0);
      chk("abort_done_n", 32'(done_n), 32'd0);
      probe_rel = -1;

      rec_clear();
      t0 = cyc;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 35; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check_basic_offsets("retry");

      rec_clear();
      t0 = cyc;
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) tick(1'b0, 1'b0, 1'b0, i == 10);
      chk("rrst_out", 32'({qa_mux, qb_mux, mem_rden, addr_adv, accum_sload,
                           mem_sel, pix_valid, busy, done}), 32'd0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 80; i++) begin
            tick($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_pixel_scheduler.md
Name: conv_pixel_scheduler

Overview:
- Sequences one convolution layer's MAC datapath: input-feature/weight M9K read enables, address-generator advance, per-pixel accumulate reload, and the time-multiplexed selection of the INPUT_NUM_MEM input-feature memories onto the single-channel MAC operand bus.
- Replaces free-running enable-driven control with an explicit start/busy/done handshake, hold (stall) and abort, so a layer-level sequencer can chain layers.
- Sits between the layer sequencer and the address generators, feature/weight memories and MAC array.

Parameters:
- DATA_WIDTH, 16, width of one feature word.
- INPUT_NUM_MEM, 20, number of input-feature memories multiplexed per output pixel.
- CYCLES_PER_MEM, 25, MAC cycles spent on each memory per pixel (kernel taps).
- OUT_FEATURE_WIDTH, 10, output map width; the map is square.
- NUM_ONEMULT, 2, output maps computed serially per MAC.
- PIPE_LAT, 4, cycles from read enable to MAC result; PIPE_LAT is at least 1.
- Derived values:
  - PIX_CYC = INPUT_NUM_MEM*CYCLES_PER_MEM.
  - NUM_PIX = OUT_FEATURE_WIDTH^2*NUM_ONEMULT.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle request; honoured only in IDLE.
- hold  in  1  stall; freezes RUN progress.
- abort  in  1  returns to IDLE; done is not pulsed.
- in_feature_q_a_all  in  DATA_WIDTH*INPUT_NUM_MEM  port-A words, memory k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_feature_q_b_all  in  DATA_WIDTH*INPUT_NUM_MEM  port-B words, same packing.
- in_feature_q_a_mux  out  DATA_WIDTH  registered selected port-A word.
- in_feature_q_b_mux  out  DATA_WIDTH  registered selected port-B word.
- mem_rden  out  1  feature and weight read enables, both ports.
- addr_adv  out  1  address-generator advance.
- accum_sload  out  1  MAC accumulator reload.
- mem_sel  out  clog2(INPUT_NUM_MEM)  current memory index.
- pix_valid  out  1  MAC output of a completed pixel is valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0; pix_valid shift register cleared.
- Registered state machine: IDLE -> PRIME -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 moves to PRIME next cycle.
  - PRIME: PIPE_LAT cycles; mem_rden=1, addr_adv=1, accum_sload=0.
  - RUN: PIX_CYC*NUM_PIX unstalled cycles.
  - DRAIN: PIPE_LAT cycles; mem_rden=0, addr_adv=0.
  - DONE: one cycle, done=1, then IDLE.
- RUN counters:
  - tap_cnt counts 0..CYCLES_PER_MEM-1; on wrap, mem_sel increments 0..INPUT_NUM_MEM-1.
  - On mem_sel wrap, pix_cnt increments 0..NUM_PIX-1.
  - No divider is used; the counters are nested.
- RUN outputs:
  - mem_rden=addr_adv=!hold.
  - accum_sload=1 when tap_cnt==0, mem_sel==0 and hold==0.
- hold in RUN: counters freeze and mem_rden/addr_adv drop in the same cycle (combinational gating).
- hold in PRIME, DRAIN or IDLE is ignored.
- Operand mux:
  - in_feature_q_*_mux updates every cycle with the word of memory mem_sel, giving 1-cycle latency.
  - It holds its value while hold=1.
  - It clears to 0 in IDLE.
- pix_valid:
  - An unstalled RUN cycle with tap_cnt==CYCLES_PER_MEM-1 and mem_sel==INPUT_NUM_MEM-1 enters a PIPE_LAT-deep shift register.
  - pix_valid is the shift register output; it shifts every cycle regardless of hold.
- The final pixel's pix_valid occurs in the last DRAIN cycle; done follows one cycle later.
- Last RUN cycle: tap, mem and pix counters all at maximum and unstalled. The next state is DRAIN and the counters return to 0.
- start while busy: ignored. start coincident with reset: reset wins.
- abort, any non-IDLE state: next cycle IDLE, counters and shift register cleared, done stays 0. abort has priority over hold and start.
- Mid-operation reset: same clearing as abort, plus all outputs go to 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, PRIME, RUN, DRAIN, DONE);
  - the derived constants PIX_CYC and NUM_PIX;
  - the counter width function clog2.
- One sub-module is natural: feature_word_mux, a parameterised registered N-to-1 word selector with hold and clear. It is instantiated twice, for ports A and B.

Test Plan:
All scenarios use INPUT_NUM_MEM=3, CYCLES_PER_MEM=2, OUT_FEATURE_WIDTH=2, NUM_ONEMULT=1, PIPE_LAT=2.
- Basic run: start at cycle 0 -> busy rises at cycle 1; PRIME at cycles 1-2; RUN at cycles 3-26; DRAIN at cycles 27-28; done=1 only at cycle 29.
- Reload and pixel timing: accum_sload=1 at cycles 3, 9, 15, 21 only; pix_valid=1 at cycles 10, 16, 22, 28; mem_sel sequence per pixel is 0,0,1,1,2,2.
- Operand mux: memory k driven with constant value 0x100+k -> in_feature_q_a_mux equals 0x100+mem_sel of the previous cycle; port B behaves the same.
- Hold: hold=1 for 3 cycles starting at cycle 5 -> mem_rden=0 and mem_sel frozen for those cycles; done moves to cycle 32; pix_valid count stays 4.
- Abort and retry: abort at cycle 12 -> IDLE at cycle 13, done never pulses; a later start runs a full clean sequence with pix_valid at the same offsets as the basic run.
- Protocol checks: start pulsed at cycle 8 of a run is ignored; reset asserted in RUN drives every output to 0 next cycle.
